// File: rtl/pattern_player_if.sv
// Command/status bundle between a pattern_player and whatever drives it.
// master: the controller side (issues start/abort and the pattern setup).
// slave:  the player itself.
interface pattern_player_if #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
);
  logic               start;
  logic               abort;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   length;
  logic               loop;
  logic               det_in;
  logic               det_tick;
  logic               busy;
  logic               done;
  logic [LEN_W-1:0]   bits_sent;

  modport master (
    output start, abort, pattern, length, loop,
    input  det_in, det_tick, busy, done, bits_sent
  );

  modport slave (
    input  start, abort, pattern, length, loop,
    output det_in, det_tick, busy, done, bits_sent
  );
endinterface

// File: rtl/pattern_player.sv
// Plays a stored bit pattern as (det_in, det_tick) pairs at one bit per
// TICK_DIV clocks, MSB of the active length first. Used to drive the
// sequence detector on the board without manual button presses.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; bits_sent holds the last pass count
// RUN    | emitting bits; divider counts down to the next tick
// FINISH | one-cycle done pulse after a non-looping pass (or len=0)
module pattern_player #(
  parameter int TICK_DIV = 100_000_000,
  parameter int MAX_LEN  = 16,
  parameter int LEN_W    = 5
) (
  input logic              clk_100M,
  input logic              reset,
  pattern_player_if.slave  pp
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [MAX_LEN-1:0] pat_sh_q, pat_sh_d;
  logic [LEN_W-1:0]   len_sh_q, len_sh_d;
  logic               loop_sh_q, loop_sh_d;
  logic [LEN_W-1:0]   bits_sent_q, bits_sent_d;

  logic [LEN_W-1:0]   len_clamped;
  logic               tick;
  logic               bit_out;
  logic               busy;
  logic               done;

  assign len_clamped = (pp.length > LEN_MAX) ? LEN_MAX : pp.length;

  // State, divider, play index and shadow copies of the setup inputs.
  always_ff @(posedge clk_100M) begin
    if (reset) begin
      state_q     <= IDLE;
      div_q       <= '0;
      idx_q       <= '0;
      pat_sh_q    <= '0;
      len_sh_q    <= '0;
      loop_sh_q   <= 1'b0;
      bits_sent_q <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      pat_sh_q    <= pat_sh_d;
      len_sh_q    <= len_sh_d;
      loop_sh_q   <= loop_sh_d;
      bits_sent_q <= bits_sent_d;
    end
  end

  // Next-state and output decode; abort wins over everything in RUN,
  // including a tick that would otherwise land on the same cycle.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    idx_d       = idx_q;
    pat_sh_d    = pat_sh_q;
    len_sh_d    = len_sh_q;
    loop_sh_d   = loop_sh_q;
    bits_sent_d = bits_sent_q;
    tick        = 1'b0;
    bit_out     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (pp.start && !pp.abort) begin
          pat_sh_d    = pp.pattern;
          len_sh_d    = len_clamped;
          loop_sh_d   = pp.loop;
          bits_sent_d = '0;
          // Divider cleared so the first tick lands on the very next cycle.
          div_d       = '0;
          idx_d       = IDX_W'(len_clamped - LEN_W'(1));
          state_d     = (len_clamped == '0) ? FINISH : RUN;
        end
      end

      RUN: begin
        busy = 1'b1;
        if (pp.abort) begin
          state_d = IDLE;
        end else if (div_q == '0) begin
          tick    = 1'b1;
          bit_out = pat_sh_q[idx_q];
          div_d   = DIV_LAST;
          // A full count means the previous tick closed a pass.
          bits_sent_d = (bits_sent_q == len_sh_q) ? LEN_W'(1)
                                                  : bits_sent_q + LEN_W'(1);
          if (idx_q == '0) begin
            if (loop_sh_q) begin
              idx_d = IDX_W'(len_sh_q - LEN_W'(1));
            end else begin
              state_d = FINISH;
            end
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end

      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign pp.det_tick  = tick;
  assign pp.det_in    = bit_out;
  assign pp.busy      = busy;
  assign pp.done      = done;
  assign pp.bits_sent = bits_sent_q;

endmodule

// File: tb/tb_pattern_player.sv
// Bench for pattern_player: directed scenarios followed by random traffic,
// every cycle compared against a start-relative timing model.
module tb_pattern_player;

  localparam int TD      = 4;
  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;

  logic clk;
  logic rst;

  pattern_player_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) pp ();

  pattern_player #(.TICK_DIV(TD), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk_100M (clk),
    .reset    (rst),
    .pp       (pp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: a run is described by its start cycle and setup;
  // everything else is derived from elapsed time.
  int          m_st   = 0;    // 0 idle, 1 playing, 2 done-pulse cycle
  int          m_s    = 0;
  int          m_len  = 0;
  logic [15:0] m_pat  = '0;
  logic        m_loop = 1'b0;
  int          m_bits = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic st, input logic ab,
                      input logic [15:0] pat, input logic [4:0] len,
                      input logic lp);
    int k, j, e_tick, e_in, e_busy, e_done;
    rst        = r;
    pp.start   = st;
    pp.abort   = ab;
    pp.pattern = pat;
    pp.length  = len;
    pp.loop    = lp;
    #1;
    e_tick = 0; e_in = 0; e_busy = 0; e_done = 0; j = 0;
    if (m_st == 1) begin
      e_busy = 1;
      k = cyc - m_s - 1;
      if ((k % TD) == 0 && !ab) begin
        e_tick = 1;
        j      = k / TD;
        e_in   = int'(m_pat[m_len - 1 - (j % m_len)]);
      end
    end else if (m_st == 2) begin
      e_done = 1;
    end
    chk("det_tick",  int'(pp.det_tick),  e_tick);
    chk("det_in",    int'(pp.det_in),    e_in);
    chk("busy",      int'(pp.busy),      e_busy);
    chk("done",      int'(pp.done),      e_done);
    chk("bits_sent", int'(pp.bits_sent), m_bits);

    if (r) begin
      m_st   = 0;
      m_bits = 0;
    end else begin
      case (m_st)
        0: if (st && !ab) begin
             m_s    = cyc;
             m_len  = (int'(len) > MAX_LEN) ? MAX_LEN : int'(len);
             m_pat  = pat;
             m_loop = lp;
             m_bits = 0;
             m_st   = (m_len == 0) ? 2 : 1;
           end
        1: if (ab) begin
             m_st = 0;
           end else if (e_tick == 1) begin
             m_bits = (j % m_len) + 1;
             if (!m_loop && j == m_len - 1) m_st = 2;
           end
        default: m_st = 0;
      endcase
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'($urandom), 5'($urandom), 1'($urandom));
  endtask

  initial begin
    rst        = 1'b1;
    pp.start   = 1'b0;
    pp.abort   = 1'b0;
    pp.pattern = '0;
    pp.length  = '0;
    pp.loop    = 1'b0;
    repeat (3) @(negedge clk);

    // Plain 4-bit run.
    idle(3);
    step(1'b0, 1'b1, 1'b0, 16'h000B, 5'd4, 1'b0);
    idle(20);

    // Same run with a restart attempt and a pattern change mid-play.
    step(1'b0, 1'b1, 1'b0, 16'h000B, 5'd4, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 16'h0000, 5'd4, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'hFFF0, 5'd9, 1'b1);
    idle(18);

    // Zero length: done pulse only.
    step(1'b0, 1'b1, 1'b0, 16'hFFFF, 5'd0, 1'b0);
    idle(5);

    // Looping 3-bit pattern, aborted the cycle after the 5th tick.
    step(1'b0, 1'b1, 1'b0, 16'h0005, 5'd3, 1'b1);
    idle(17);
    step(1'b0, 1'b0, 1'b1, 16'h0005, 5'd3, 1'b1);
    idle(10);

    // Reset in the middle of a run.
    step(1'b0, 1'b1, 1'b0, 16'h000B, 5'd4, 1'b0);
    idle(5);
    step(1'b1, 1'b0, 1'b0, 16'h000B, 5'd4, 1'b0);
    idle(10);

    // Oversized length clamps to 16.
    step(1'b0, 1'b1, 1'b0, 16'hFFFF, 5'd20, 1'b0);
    idle(70);

    // Random traffic, including aborts and resets landing anywhere.
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 499) == 0),
           1'($urandom_range(0, 14) == 0),
           1'($urandom_range(0, 89) == 0),
           16'($urandom),
           5'($urandom_range(0, 20)),
           1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
